// File: rtl/csa_pipe_if.sv
// Operand/result bus of the two-stage carry-select adder pipeline.
//
// Handshake rule for both channels: a beat moves when valid && ready are both
// high at a rising clock edge. A source that raises valid holds it and its
// data stable until that happens; ready never depends on the same channel's
// valid.
interface csa_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer of operands / consumer of results (the environment).
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The adder pipeline itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe.sv
// Two-stage pipelined carry-select adder/subtractor.
// Stage 1 precomputes, for every BLK-bit block, the block sum and block carry
// for both possible carry-ins. Stage 2 walks the blocks LSB to MSB choosing
// one of the two precomputed results per block, then registers the result.
// WIDTH must be a multiple of BLK and at least BLK.
module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  csa_pipe_if.slave bus
);

  localparam int NB = WIDTH / BLK;

  // Stage enables: the output register may load when empty or being drained;
  // stage 1 may load when empty or when it can pass its beat downstream.
  logic en2;
  logic en1;

  // Stage 1 registers
  logic                   s1_valid_q;
  logic [NB-1:0][BLK-1:0] s1_sum0_q;
  logic [NB-1:0][BLK-1:0] s1_sum1_q;
  logic [NB-1:0]          s1_c0_q;
  logic [NB-1:0]          s1_c1_q;
  logic                   s1_cin_q;
  logic                   s1_amsb_q;
  logic                   s1_bmsb_q;

  // Stage 1 next-state
  logic [WIDTH-1:0]       b_eff;
  logic                   s1_cin_d;
  logic [NB-1:0][BLK-1:0] s1_sum0_d;
  logic [NB-1:0][BLK-1:0] s1_sum1_d;
  logic [NB-1:0]          s1_c0_d;
  logic [NB-1:0]          s1_c1_d;

  // Stage 2 (output) registers and next-state
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             carry_c;

  assign en2 = !out_valid_q || bus.out_ready;
  assign en1 = !s1_valid_q || en2;

  assign bus.in_ready  = en1;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Stage 1 logic: effective operand, resolved carry-in, and both conditional
  // results of every block. Subtraction is a + ~b + 1, so cin is ignored then.
  always_comb begin
    b_eff     = bus.sub ? ~bus.b : bus.b;
    s1_cin_d  = bus.sub | bus.cin;
    s1_sum0_d = '0;
    s1_sum1_d = '0;
    s1_c0_d   = '0;
    s1_c1_d   = '0;
    for (int k = 0; k < NB; k++) begin
      {s1_c0_d[k], s1_sum0_d[k]} = {1'b0, bus.a[k*BLK +: BLK]}
                                 + {1'b0, b_eff[k*BLK +: BLK]};
      {s1_c1_d[k], s1_sum1_d[k]} = {1'b0, bus.a[k*BLK +: BLK]}
                                 + {1'b0, b_eff[k*BLK +: BLK]}
                                 + {{BLK{1'b0}}, 1'b1};
    end
  end

  // Stage 1 registers: load a new beat when enabled; an advancing stage with
  // no incoming beat only clears its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum0_q  <= '0;
      s1_sum1_q  <= '0;
      s1_c0_q    <= '0;
      s1_c1_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
    end else if (en1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum0_q <= s1_sum0_d;
        s1_sum1_q <= s1_sum1_d;
        s1_c0_q   <= s1_c0_d;
        s1_c1_q   <= s1_c1_d;
        s1_cin_q  <= s1_cin_d;
        s1_amsb_q <= bus.a[WIDTH-1];
        s1_bmsb_q <= b_eff[WIDTH-1];
      end
    end
  end

  // Stage 2 logic: ripple the block carry through 2:1 selects, then derive
  // signed overflow from the effective operand MSBs and the result MSB.
  always_comb begin
    carry_c = s1_cin_q;
    sum_d   = '0;
    for (int k = 0; k < NB; k++) begin
      sum_d[k*BLK +: BLK] = carry_c ? s1_sum1_q[k] : s1_sum0_q[k];
      carry_c             = carry_c ? s1_c1_q[k]   : s1_c0_q[k];
    end
    cout_d = carry_c;
    ovf_d  = (s1_amsb_q == s1_bmsb_q) && (sum_d[WIDTH-1] != s1_amsb_q);
  end

  // Output registers: hold while stalled, take stage 1's beat when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule
